// File: rtl/alu_checker.sv
// Self-checking response monitor for the 32-bit ALU: stage 1 captures a transaction, stage 2
// recomputes the expected outputs, compares, and keeps counters plus the first failure.
module alu_checker #(
    parameter int unsigned NUM_SAMPLES = 1000,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    input  logic        unsig,
    input  logic [31:0] aluout,
    input  logic        compout,
    input  logic        overflow,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] sample_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] skip_cnt,
    output logic        fail_valid,
    output logic [31:0] fail_a,
    output logic [31:0] fail_b,
    output logic [3:0]  fail_op,
    output logic [33:0] fail_got
);

    localparam logic [15:0] NumSamples = 16'(NUM_SAMPLES);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [2:0]  s1_op_q, s1_op_d;
    logic        s1_unsig_q, s1_unsig_d;
    logic [33:0] s1_got_q, s1_got_d;
    logic [15:0] acc_cnt_q, acc_cnt_d;
    logic [15:0] sample_cnt_q, sample_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] skip_cnt_q, skip_cnt_d;
    logic        fail_valid_q, fail_valid_d;
    logic [31:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
    logic [3:0]  fail_op_q, fail_op_d;
    logic [33:0] fail_got_q, fail_got_d;

    logic [31:0] sum, diff, exp_res;
    logic        checked, exp_lt, exp_ovf, mismatch, accept, last, halt_now;

    // Expected-value datapath on the stage-1 registers
    always_comb begin
        sum     = s1_a_q + s1_b_q;
        diff    = s1_a_q - s1_b_q;
        checked = 1'b1;
        exp_res = '0;
        case (s1_op_q)
            3'b000:  exp_res = s1_a_q & s1_b_q;
            3'b001:  exp_res = s1_a_q | s1_b_q;
            3'b010:  exp_res = sum;
            3'b100:  exp_res = ~(s1_a_q | s1_b_q);
            3'b101:  exp_res = s1_a_q ^ s1_b_q;
            3'b110:  exp_res = diff;
            default: checked = 1'b0;
        endcase
        exp_lt  = s1_unsig_q ? (s1_a_q < s1_b_q) : ($signed(s1_a_q) < $signed(s1_b_q));
        exp_ovf = !s1_unsig_q &&
                  (((s1_op_q == 3'b010) && (s1_a_q[31] == s1_b_q[31]) && (sum[31] != s1_a_q[31])) ||
                   ((s1_op_q == 3'b110) && (s1_a_q[31] != s1_b_q[31]) && (diff[31] != s1_a_q[31])));
        mismatch = checked && (s1_got_q != {exp_ovf, exp_lt, exp_res});
        accept   = (state_q == StRun) && in_valid && !start && (acc_cnt_q < NumSamples);
        last     = (16'(sample_cnt_q + 16'd1) == NumSamples);
        halt_now = (state_q == StRun) && s1_valid_q && (last || (STOP_ON_ERR && mismatch));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StRun;
        end else if (halt_now) begin
            state_d = StHalt;
        end
    end

    always_comb begin
        s1_valid_d   = 1'b0;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_op_d      = s1_op_q;
        s1_unsig_d   = s1_unsig_q;
        s1_got_d     = s1_got_q;
        acc_cnt_d    = acc_cnt_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        skip_cnt_d   = skip_cnt_q;
        fail_valid_d = fail_valid_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;
        fail_op_d    = fail_op_q;
        fail_got_d   = fail_got_q;
        if (start) begin
            acc_cnt_d    = '0;
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            skip_cnt_d   = '0;
            fail_valid_d = 1'b0;
            fail_a_d     = '0;
            fail_b_d     = '0;
            fail_op_d    = '0;
            fail_got_d   = '0;
        end else begin
            if (accept) begin
                // A transaction entering stage 1 as the checker halts is discarded
                s1_valid_d = !halt_now;
                s1_a_d     = a;
                s1_b_d     = b;
                s1_op_d    = op;
                s1_unsig_d = unsig;
                s1_got_d   = {overflow, compout, aluout};
                acc_cnt_d  = acc_cnt_q + 16'd1;
            end
            if (s1_valid_q) begin
                sample_cnt_d = sample_cnt_q + 16'd1;
                if (!checked) begin
                    skip_cnt_d = skip_cnt_q + 16'd1;
                end else if (mismatch) begin
                    err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_a_d     = s1_a_q;
                        fail_b_d     = s1_b_q;
                        fail_op_d    = {s1_unsig_q, s1_op_q};
                        fail_got_d   = s1_got_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= '0;
            s1_unsig_q   <= 1'b0;
            s1_got_q     <= '0;
            acc_cnt_q    <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            skip_cnt_q   <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_op_q    <= '0;
            fail_got_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s1_unsig_q   <= s1_unsig_d;
            s1_got_q     <= s1_got_d;
            acc_cnt_q    <= acc_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
            fail_valid_q <= fail_valid_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
            fail_op_q    <= fail_op_d;
            fail_got_q   <= fail_got_d;
        end
    end

    always_comb begin
        busy       = (state_q == StRun) || s1_valid_q;
        done       = (state_q == StHalt);
        pass       = (state_q == StHalt) && (err_cnt_q == 16'd0);
        sample_cnt = sample_cnt_q;
        err_cnt    = err_cnt_q;
        skip_cnt   = skip_cnt_q;
        fail_valid = fail_valid_q;
        fail_a     = fail_a_q;
        fail_b     = fail_b_q;
        fail_op    = fail_op_q;
        fail_got   = fail_got_q;
    end

endmodule
